// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_pkg
// Description : Shared types and helpers for the register file write-side
//               controller: load-tracking FSM states and the destination
//               address legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_pkg;

  // Register file address width (x0..x31).
  localparam int unsigned c_RF_ADDR_W = 5;

  // Load tracking FSM: at most one load is outstanding at a time.
  typedef enum logic [0:0] {
    RfWrIdle     = 1'b0,
    RfWrLoadPend = 1'b1
  } rf_wr_state_e;

  // A destination is illegal on an RV32E core when it names x16..x31.
  function automatic logic rf_wr_rd_illegal(input logic [c_RF_ADDR_W-1:0] rd,
                                            input logic                   rv32e);
    return rv32e & rd[c_RF_ADDR_W-1];
  endfunction

  // The write stage is only loaded for a non-zero, legal destination.
  function automatic logic rf_wr_rd_writable(input logic [c_RF_ADDR_W-1:0] rd,
                                             input logic                   rv32e);
    return (rd != '0) & ~rf_wr_rd_illegal(rd, rv32e);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_rf_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_bypass_mux
// Description : Single read-port bypass. Forwards the in-flight register file
//               write onto the read port when it targets the same, non-zero
//               register; otherwise passes the raw register file data.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_bypass_mux
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                   we_i,
  input  logic [c_RF_ADDR_W-1:0] waddr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [c_RF_ADDR_W-1:0] raddr_i,
  input  logic [DataWidth-1:0]   rf_rdata_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic w_hit;

  // x0 is hard-wired to zero in the register file, so it is never forwarded.
  assign w_hit = we_i & (waddr_i == raddr_i) & (raddr_i != '0);

  // Purely combinational: the register file only holds the value one cycle
  // after the write stage presents it.
  always_comb begin
    rdata_o = rf_rdata_i;
    if (w_hit) begin
      rdata_o = wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ibex_rf_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_write_ctrl
// Description : Write-side controller for the flop-based register file.
//               Tracks the single outstanding load, arbitrates the write port
//               between execute results and load responses, registers the
//               winning write for one cycle, bypasses it onto both read ports
//               and stalls decode on a read-after-load hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_write_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  // Execute stage result
  input  logic                   ex_valid_i,
  input  logic [c_RF_ADDR_W-1:0] ex_rd_i,
  input  logic [DataWidth-1:0]   ex_wdata_i,
  output logic                   ex_ready_o,

  // Load/store unit
  input  logic                   lsu_req_i,
  input  logic [c_RF_ADDR_W-1:0] lsu_rd_i,
  input  logic                   lsu_rvalid_i,
  input  logic [DataWidth-1:0]   lsu_rdata_i,
  input  logic                   lsu_err_i,

  // Decode read ports
  input  logic [c_RF_ADDR_W-1:0] raddr_a_i,
  input  logic [c_RF_ADDR_W-1:0] raddr_b_i,
  input  logic [DataWidth-1:0]   rf_rdata_a_i,
  input  logic [DataWidth-1:0]   rf_rdata_b_i,
  output logic [DataWidth-1:0]   rdata_a_o,
  output logic [DataWidth-1:0]   rdata_b_o,

  // Register file write port
  output logic [c_RF_ADDR_W-1:0] waddr_a_o,
  output logic [DataWidth-1:0]   wdata_a_o,
  output logic                   we_a_o,

  // Status
  output logic                   stall_o,
  output logic                   err_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  rf_wr_state_e           r_state;
  logic [c_RF_ADDR_W-1:0] r_pend_rd;
  logic                   r_err;
  logic                   r_we;
  logic [c_RF_ADDR_W-1:0] r_waddr;
  logic [DataWidth-1:0]   r_wdata;

  // --------------------------------------------------------------------------
  // Arbitration and write qualification
  // --------------------------------------------------------------------------
  logic                   w_load_pend;
  logic                   w_load_resp;
  logic                   w_cand_valid;
  logic [c_RF_ADDR_W-1:0] w_cand_rd;
  logic [DataWidth-1:0]   w_cand_wdata;
  logic                   w_rv32e;
  logic                   w_wr_en;
  logic                   w_addr_err;
  logic                   w_proto_err;

  assign w_rv32e     = RV32E;
  assign w_load_pend = (r_state == RfWrLoadPend);
  // Only a response to a tracked load competes for the write port.
  assign w_load_resp = w_load_pend & lsu_rvalid_i;

  // The load response owns the port in its cycle; execute holds its result.
  assign ex_ready_o = ~w_load_resp;

  // Select the write candidate: load response first, then execute.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_rd    = ex_rd_i;
    w_cand_wdata = ex_wdata_i;
    if (w_load_resp) begin
      // A bus error still retires the load but never updates the register.
      w_cand_valid = ~lsu_err_i;
      w_cand_rd    = r_pend_rd;
      w_cand_wdata = lsu_rdata_i;
    end else if (ex_valid_i) begin
      w_cand_valid = 1'b1;
    end
  end

  assign w_wr_en    = w_cand_valid & rf_wr_rd_writable(w_cand_rd, w_rv32e);
  assign w_addr_err = w_cand_valid & rf_wr_rd_illegal(w_cand_rd, w_rv32e);

  // A second load while one is pending, or a response with nothing pending.
  assign w_proto_err = (w_load_pend  & lsu_req_i    & ~lsu_rvalid_i) |
                       (~w_load_pend & lsu_rvalid_i);

  // --------------------------------------------------------------------------
  // Load tracking FSM with registered error pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= RfWrIdle;
      r_pend_rd <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_proto_err | w_addr_err;
      unique case (r_state)
        RfWrIdle: begin
          if (lsu_req_i) begin
            r_state   <= RfWrLoadPend;
            r_pend_rd <= lsu_rd_i;
          end
        end
        RfWrLoadPend: begin
          // A request without a response is ignored; pend_rd is kept.
          if (lsu_rvalid_i) begin
            if (lsu_req_i) begin
              r_pend_rd <= lsu_rd_i;
            end else begin
              r_state <= RfWrIdle;
            end
          end
        end
        default: begin
          r_state <= RfWrIdle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write stage: enable lasts one cycle, address/data hold when idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wr_en;
      if (w_wr_en) begin
        r_waddr <= w_cand_rd;
        r_wdata <= w_cand_wdata;
      end
    end
  end

  assign we_a_o    = r_we;
  assign waddr_a_o = r_waddr;
  assign wdata_a_o = r_wdata;
  assign err_o     = r_err;

  // --------------------------------------------------------------------------
  // Read-after-load hazard, from registered state so it covers the response
  // cycle; the bypass then supplies the data in the following cycle.
  // --------------------------------------------------------------------------
  assign stall_o = w_load_pend & (r_pend_rd != '0) &
                   ((raddr_a_i == r_pend_rd) | (raddr_b_i == r_pend_rd));

  // --------------------------------------------------------------------------
  // Read port bypass
  // --------------------------------------------------------------------------
  ibex_rf_bypass_mux #(
    .DataWidth (DataWidth)
  ) u_bypass_a (
    .we_i       (r_we),
    .waddr_i    (r_waddr),
    .wdata_i    (r_wdata),
    .raddr_i    (raddr_a_i),
    .rf_rdata_i (rf_rdata_a_i),
    .rdata_o    (rdata_a_o)
  );

  ibex_rf_bypass_mux #(
    .DataWidth (DataWidth)
  ) u_bypass_b (
    .we_i       (r_we),
    .waddr_i    (r_waddr),
    .wdata_i    (r_wdata),
    .raddr_i    (raddr_b_i),
    .rf_rdata_i (rf_rdata_b_i),
    .rdata_o    (rdata_b_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rf_write_ctrl
// Description : Directed bench for ibex_rf_write_ctrl. Expected register file
//               writes and error pulses are queued when stimulus is issued
//               and retired by an independent monitor; combinational outputs
//               and reset values are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_write_ctrl;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ex_valid, lsu_req, lsu_rvalid, lsu_err;
  logic [4:0]  ex_rd, lsu_rd, raddr_a, raddr_b;
  logic [31:0] ex_wdata, lsu_rdata, rf_rdata_a, rf_rdata_b;
  logic        ex_ready, we, stall, err;
  logic [31:0] rdata_a, rdata_b, wdata;
  logic [4:0]  waddr;

  // Second instance configured as RV32E, driven only by its own ex_valid.
  logic        ex_valid_e;
  logic        zero1 = 1'b0;
  logic [4:0]  zero5 = 5'd0;
  logic [31:0] zero32 = 32'd0;
  logic        ex_ready_e, we_e, stall_e, err_e;
  logic [31:0] rdata_a_e, rdata_b_e, wdata_e;
  logic [4:0]  waddr_e;

  int  vectors = 0;
  int  miscompares = 0;
  wr_t exp_wr[$];
  int  pending_err = 0;
  wr_t mon_e;

  always #5 clk = ~clk;

  ibex_rf_write_ctrl #(.DataWidth(32), .RV32E(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_req_i(lsu_req), .lsu_rd_i(lsu_rd), .lsu_rvalid_i(lsu_rvalid),
    .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b),
    .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we),
    .stall_o(stall), .err_o(err)
  );

  ibex_rf_write_ctrl #(.DataWidth(32), .RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_e), .ex_rd_i(ex_rd), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready_e),
    .lsu_req_i(zero1), .lsu_rd_i(zero5), .lsu_rvalid_i(zero1),
    .lsu_rdata_i(zero32), .lsu_err_i(zero1),
    .raddr_a_i(zero5), .raddr_b_i(zero5),
    .rf_rdata_a_i(zero32), .rf_rdata_b_i(zero32),
    .rdata_a_o(rdata_a_e), .rdata_b_o(rdata_b_e),
    .waddr_a_o(waddr_e), .wdata_a_o(wdata_e), .we_a_o(we_e),
    .stall_o(stall_e), .err_o(err_e)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t t;
    t.a = a;
    t.d = d;
    exp_wr.push_back(t);
  endtask

  // Monitor: retire queued writes and error pulses as the DUT presents them.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, waddr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("write_addr", {27'd0, waddr}, {27'd0, mon_e.a});
        chk("write_data", wdata, mon_e.d);
      end
    end
    if (err === 1'b1) begin
      if (pending_err == 0) begin
        chk("unexpected_err", 32'd1, 32'd0);
      end else begin
        pending_err--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    ex_valid = 0; ex_rd = 0; ex_wdata = 0; ex_valid_e = 0;
    lsu_req = 0; lsu_rd = 0; lsu_rvalid = 0; lsu_rdata = 0; lsu_err = 0;
    raddr_a = 0; raddr_b = 0; rf_rdata_a = 0; rf_rdata_b = 0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    rst_ni = 1'b1;

    // Execute write and bypass
    ex_valid = 1; ex_rd = 5; ex_wdata = 32'hA5A5_0001;
    expect_wr(5, 32'hA5A5_0001);
    @(negedge clk); chk("t1_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 0; raddr_a = 5; rf_rdata_a = 0; raddr_b = 0; rf_rdata_b = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_we", {31'd0, we}, 32'd1);
    chk("t1_bypass_a", rdata_a, 32'hA5A5_0001);
    chk("t1_passthru_b", rdata_b, 32'hDEAD_BEEF);
    step();
    rf_rdata_a = 32'h1111_1111;
    @(negedge clk); chk("t1_no_bypass_after", rdata_a, 32'h1111_1111);

    // Load hazard
    step();
    raddr_a = 0; raddr_b = 7; rf_rdata_b = 0;
    lsu_req = 1; lsu_rd = 7;
    @(negedge clk); chk("t2_stall_idle", {31'd0, stall}, 32'd0);
    step();
    lsu_req = 0;
    @(negedge clk); chk("t2_stall_pend", {31'd0, stall}, 32'd1);
    step();
    lsu_rvalid = 1; lsu_rdata = 32'h0000_1234;
    expect_wr(7, 32'h0000_1234);
    @(negedge clk);
    chk("t2_stall_rvalid", {31'd0, stall}, 32'd1);
    chk("t2_ex_ready_resp", {31'd0, ex_ready}, 32'd0);
    step();
    lsu_rvalid = 0;
    @(negedge clk);
    chk("t2_stall_after", {31'd0, stall}, 32'd0);
    chk("t2_bypass_b", rdata_b, 32'h0000_1234);

    // Arbitration: load wins, execute follows
    step();
    raddr_b = 0;
    lsu_req = 1; lsu_rd = 3;
    step();
    lsu_req = 0;
    lsu_rvalid = 1; lsu_rdata = 32'h33;
    ex_valid = 1; ex_rd = 4; ex_wdata = 32'h44;
    expect_wr(3, 32'h33);
    @(negedge clk); chk("t3_ex_ready_blocked", {31'd0, ex_ready}, 32'd0);
    step();
    lsu_rvalid = 0;
    expect_wr(4, 32'h44);
    @(negedge clk); chk("t3_ex_ready_free", {31'd0, ex_ready}, 32'd1);
    // Back-to-back execute writes
    step(); ex_rd = 10; ex_wdata = 32'hA; expect_wr(10, 32'hA);
    step(); ex_rd = 11; ex_wdata = 32'hB; expect_wr(11, 32'hB);
    step(); ex_rd = 12; ex_wdata = 32'hC; expect_wr(12, 32'hC);
    @(negedge clk);
    chk("t3_b2b_we", {31'd0, we}, 32'd1);
    chk("t3_b2b_waddr", {27'd0, waddr}, 32'd11);
    step(); ex_valid = 0;

    // Suppression: load to x0, load with bus error
    lsu_req = 1; lsu_rd = 0; raddr_a = 0; raddr_b = 0;
    step();
    lsu_req = 0;
    @(negedge clk); chk("t4_x0_no_stall", {31'd0, stall}, 32'd0);
    step();
    lsu_rvalid = 1; lsu_rdata = 32'h5;
    step();
    lsu_rvalid = 0;
    lsu_req = 1; lsu_rd = 9; raddr_a = 9;
    step();
    lsu_req = 0;
    @(negedge clk); chk("t4_err_load_stall", {31'd0, stall}, 32'd1);
    step();
    lsu_rvalid = 1; lsu_err = 1; lsu_rdata = 32'h99;
    step();
    lsu_rvalid = 0; lsu_err = 0; rf_rdata_a = 32'h2222;
    @(negedge clk);
    chk("t4_idle_after_err", {31'd0, stall}, 32'd0);
    chk("t4_no_bypass_err", rdata_a, 32'h2222);

    // Back-to-back loads
    step();
    raddr_a = 0;
    lsu_req = 1; lsu_rd = 13;
    step();
    lsu_rvalid = 1; lsu_rdata = 32'hD; lsu_rd = 14;
    expect_wr(13, 32'hD);
    step();
    lsu_req = 0; lsu_rvalid = 0; raddr_a = 14;
    @(negedge clk); chk("t5_b2b_stall_new_rd", {31'd0, stall}, 32'd1);
    step();
    lsu_rvalid = 1; lsu_rdata = 32'hE;
    expect_wr(14, 32'hE);
    step();
    lsu_rvalid = 0;
    @(negedge clk); chk("t5_b2b_bypass", rdata_a, 32'hE);

    // Protocol errors
    step();
    raddr_a = 0;
    lsu_rvalid = 1; lsu_rdata = 32'hBAD; pending_err++;
    @(negedge clk); chk("t6_ex_ready_idle", {31'd0, ex_ready}, 32'd1);
    step();
    lsu_rvalid = 0;
    @(negedge clk); chk("t6_err_idle_rvalid", {31'd0, err}, 32'd1);
    step();
    lsu_req = 1; lsu_rd = 6;
    @(negedge clk); chk("t6_err_one_cycle", {31'd0, err}, 32'd0);
    step();
    lsu_rd = 8; pending_err++;
    step();
    lsu_req = 0;
    lsu_rvalid = 1; lsu_rdata = 32'h66;
    expect_wr(6, 32'h66);
    @(negedge clk); chk("t6_err_second_req", {31'd0, err}, 32'd1);
    step();
    lsu_rvalid = 0; raddr_a = 6;
    @(negedge clk); chk("t6_kept_first_rd", rdata_a, 32'h66);

    // RV32E illegal destination
    step();
    raddr_a = 0;
    ex_valid_e = 1; ex_rd = 17; ex_wdata = 32'h17;
    step();
    ex_rd = 3; ex_wdata = 32'h77;
    @(negedge clk);
    chk("t7_rv32e_err", {31'd0, err_e}, 32'd1);
    chk("t7_rv32e_no_we", {31'd0, we_e}, 32'd0);
    step();
    ex_valid_e = 0;
    @(negedge clk);
    chk("t7_rv32e_legal_we", {31'd0, we_e}, 32'd1);
    chk("t7_rv32e_legal_waddr", {27'd0, waddr_e}, 32'd3);
    chk("t7_rv32e_legal_wdata", wdata_e, 32'h77);
    chk("t7_rv32e_err_clear", {31'd0, err_e}, 32'd0);

    // Reset mid-load with a write in flight
    step();
    lsu_req = 1; lsu_rd = 20;
    ex_valid = 1; ex_rd = 21; ex_wdata = 32'h2121;
    step();
    rst_ni = 0; lsu_req = 0; ex_valid = 0; raddr_a = 20;
    #1;
    chk("t8_rst_we", {31'd0, we}, 32'd0);
    chk("t8_rst_waddr", {27'd0, waddr}, 32'd0);
    chk("t8_rst_wdata", wdata, 32'd0);
    chk("t8_rst_stall", {31'd0, stall}, 32'd0);
    chk("t8_rst_err", {31'd0, err}, 32'd0);
    step();
    rst_ni = 1;
    lsu_rvalid = 1; lsu_rdata = 32'h2020; pending_err++;
    @(negedge clk); chk("t8_ex_ready_idle", {31'd0, ex_ready}, 32'd1);
    step();
    lsu_rvalid = 0;
    @(negedge clk);
    chk("t8_late_rvalid_err", {31'd0, err}, 32'd1);
    chk("t8_late_rvalid_no_we", {31'd0, we}, 32'd0);

    repeat (3) step();
    chk("final_writes_drained", exp_wr.size(), 32'd0);
    chk("final_errs_drained", pending_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
